power_result_fifo: RTL and testbench
====================================

Name: power_result_fifo

Overview:
- Downstream stage of the x^8 power pipeline. It captures each 32-bit result and its valid strobe, and buffers results in a FIFO.
- It presents results to the consumer over a valid/ready handshake.
- The power pipeline cannot be stalled, so this block absorbs consumer backpressure. It drops and counts results that arrive when the FIFO is full.
- It also reports occupancy and a sticky overflow flag for debug and status.

Parameters:
- DATA_W, 32, width of each buffered result; matches the power pipeline output.
- DEPTH, 8, FIFO entries; must be a power of two and >= 2.
- DROP_W, 8, width of the saturating drop counter.
- Derived constants: PTR_W = log2(DEPTH); CNT_W = PTR_W+1.

Ports:
- clock  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- i_value  in  DATA_W  result from the power pipeline.
- i_valid  in  1  qualifies i_value for one cycle; there is no ready back to the producer.
- i_clear  in  1  synchronous clear of o_overflow and o_drop_count.
- o_value  out  DATA_W  head-of-FIFO data (first-word fall-through).
- o_valid  out  1  FIFO not empty.
- o_ready  in  1  consumer accepts o_value when o_valid && o_ready.
- o_count  out  CNT_W  current occupancy, 0..DEPTH.
- o_full  out  1  o_count == DEPTH.
- o_overflow  out  1  sticky flag: at least one result was dropped.
- o_drop_count  out  DROP_W  number of dropped results, saturating.

Behaviour:
- Reset (reset low, asynchronous):
  - rd_ptr, wr_ptr and count go to 0.
  - o_valid=0, o_full=0, o_count=0, o_overflow=0, o_drop_count=0.
  - o_value reads 0 while empty; storage contents are don't-care but must not be visible.
  - Reset mid-operation discards all buffered entries immediately.
- Push: push = i_valid && (!full || pop). On a push, mem[wr_ptr] <= i_value and wr_ptr increments, wrapping modulo DEPTH.
- Pop: pop = o_valid && o_ready. On a pop, rd_ptr increments, wrapping modulo DEPTH.
- Count update:
  - push only: +1.
  - pop only: -1.
  - push and pop together: unchanged.
  - count never exceeds DEPTH and never goes below 0.
- Latency:
  - A push into an empty FIFO at edge N makes o_valid=1 and o_value equal to that data in the cycle after edge N.
  - Data is never visible in the same cycle it arrives; there is no combinational bypass from i_value to o_value.
- o_value is mem[rd_ptr] when o_valid=1, else 0.
- o_value and o_valid hold stable while o_valid && !o_ready.
- Full, with i_valid and o_ready both high: the pop frees a slot and the push is accepted. No drop occurs; count stays at DEPTH.
- Full, with i_valid high and no pop: the result is dropped. o_overflow <= 1, and o_drop_count increments, saturating at 2^DROP_W-1.
- Empty, with i_valid high and o_ready high: no pop occurs (o_valid=0), so this is a plain push.
- i_clear:
  - Sets o_overflow <= 0 and o_drop_count <= 0 on the next edge.
  - If a drop occurs in the same cycle, the drop wins: o_overflow=1 and o_drop_count=1.
  - i_clear does not affect FIFO contents.
- Consecutive i_valid cycles, one per clock, are all accepted while space remains, so the full pipeline throughput is supported.
- There is no FSM beyond the FIFO pointers and count. The status logic is registered; only o_full and o_valid are decoded from the registered count.

Decomposition:
- Shared package holds:
  - PWR_DATA_W = 32, used by both the power pipeline and this block.
  - The default FIFO depth.
  - A clog2 helper function for pointer widths.
- One sub-module is natural: sync_fifo_fwft, a generic storage array with pointers, count, full and empty.
- power_result_fifo wraps sync_fifo_fwft and adds the push-qualification, overflow and drop-counting logic.

Test Plan:
- Reset, then push 256 (2^8) with o_ready=1:
  - one cycle later, o_valid=1 and o_value=256.
  - the next cycle, o_valid=0 and o_count=0.
- With o_ready=0, push 8 consecutive values 1, 256, 6561, 65536, 390625, 1679616, 5764801, 16777216:
  - o_full=1 and o_count=8, no drop.
  - raise o_ready; the values drain in the same order, one per cycle.
- Push a 9th value, 0x98C29B81 (15^8), while full and o_ready=0:
  - o_overflow=1, o_drop_count=1, o_count stays 8.
  - the 9th value is never output.
- While full, i_valid=1 with 0x98C29B81 and o_ready=1 in the same cycle:
  - head is popped and the new value is accepted; o_count stays 8, o_overflow stays 0.
  - 0x98C29B81 emerges last.
- Drive 300 drops with DROP_W=8:
  - o_drop_count saturates at 255.
  - pulse i_clear with no drop that cycle: both status outputs go to 0.
  - pulse i_clear in a drop cycle: result is o_overflow=1 and o_drop_count=1.
- Assert reset asynchronously (between edges) with o_count=5:
  - o_valid=0, o_count=0 and o_value=0 immediately.
  - after release, the first new push is output correctly.

Source files
------------

// File: rtl/power_result_fifo_pkg.sv
// rtl/power_result_fifo_pkg.sv - shared constants and helpers for the power result path
// Holds the power pipeline data width, the default result FIFO depth and a
// ceiling-log2 helper used to size pointers.
package power_result_fifo_pkg;

   localparam int PWR_DATA_W     = 32;
   localparam int PWR_FIFO_DEPTH = 8;

   // Smallest r with 2**r >= value; returns 0 for value <= 1.
   function automatic int clog2(input int value);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// rtl/sync_fifo_fwft.sv - generic first-word fall-through synchronous FIFO
// Ports:
//   clock, reset       rising-edge clock, asynchronous active-low reset
//   push, wr_data      write strobe and data (caller guarantees push only when not full or popping)
//   pop                read strobe (caller guarantees pop only when not empty)
//   rd_data            head entry, 0 while empty
//   count, full, empty occupancy and decoded status
module sync_fifo_fwft
   import power_result_fifo_pkg::*;
#(
   parameter int DATA_W = PWR_DATA_W,
   parameter int DEPTH  = PWR_FIFO_DEPTH,
   localparam int PTR_W = clog2(DEPTH),
   localparam int CNT_W = PTR_W + 1
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              push,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              pop,
   output logic [DATA_W-1:0] rd_data,
   output logic [CNT_W-1:0]  count,
   output logic              full,
   output logic              empty
);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;

   // Storage has no reset; stale contents are masked by the empty check below.
   always_ff @(posedge clock) begin
      if (push) mem[wr_ptr] <= wr_data;
   end

   // DEPTH is a power of two, so pointer wrap is the natural overflow of PTR_W bits.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   assign full    = (count == CNT_W'(DEPTH));
   assign empty   = (count == '0);
   assign rd_data = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/power_result_fifo.sv
// rtl/power_result_fifo.sv - result buffer behind the x^8 power pipeline with drop accounting
// Ports:
//   clock, reset           rising-edge clock, asynchronous active-low reset
//   i_value, i_valid       result stream from the pipeline (no backpressure possible)
//   i_clear                synchronous clear of o_overflow and o_drop_count
//   o_value, o_valid       head result to the consumer, first-word fall-through
//   o_ready                consumer accept
//   o_count, o_full        occupancy status
//   o_overflow             sticky: a result was dropped
//   o_drop_count           saturating count of dropped results
module power_result_fifo
   import power_result_fifo_pkg::*;
#(
   parameter int DATA_W = PWR_DATA_W,
   parameter int DEPTH  = PWR_FIFO_DEPTH,
   parameter int DROP_W = 8,
   localparam int PTR_W = clog2(DEPTH),
   localparam int CNT_W = PTR_W + 1
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [DATA_W-1:0] i_value,
   input  logic              i_valid,
   input  logic              i_clear,
   output logic [DATA_W-1:0] o_value,
   output logic              o_valid,
   input  logic              o_ready,
   output logic [CNT_W-1:0]  o_count,
   output logic              o_full,
   output logic              o_overflow,
   output logic [DROP_W-1:0] o_drop_count
);

   logic push;
   logic pop;
   logic drop;
   logic empty;

   // A pop in the same cycle frees the slot, so a full FIFO still accepts.
   assign pop  = o_valid && o_ready;
   assign push = i_valid && (!o_full || pop);
   assign drop = i_valid && o_full && !pop;

   sync_fifo_fwft #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_fifo (
      .clock   (clock),
      .reset   (reset),
      .push    (push),
      .wr_data (i_value),
      .pop     (pop),
      .rd_data (o_value),
      .count   (o_count),
      .full    (o_full),
      .empty   (empty)
   );

   assign o_valid = !empty;

   // A drop coinciding with i_clear takes priority so the event is never lost.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         o_overflow   <= 1'b0;
         o_drop_count <= '0;
      end else if (drop) begin
         o_overflow <= 1'b1;
         if (i_clear)
            o_drop_count <= DROP_W'(1);
         else if (o_drop_count != '1)
            o_drop_count <= o_drop_count + DROP_W'(1);
      end else if (i_clear) begin
         o_overflow   <= 1'b0;
         o_drop_count <= '0;
      end
   end

endmodule

// File: tb/tb_power_result_fifo.sv
// tb/tb_power_result_fifo.sv - directed self-checking bench for power_result_fifo
module tb_power_result_fifo;

   localparam int DATA_W = 32;
   localparam int DEPTH  = 8;
   localparam int DROP_W = 8;
   localparam int CNT_W  = 4;

   logic              clock;
   logic              reset;
   logic [DATA_W-1:0] i_value;
   logic              i_valid;
   logic              i_clear;
   logic [DATA_W-1:0] o_value;
   logic              o_valid;
   logic              o_ready;
   logic [CNT_W-1:0]  o_count;
   logic              o_full;
   logic              o_overflow;
   logic [DROP_W-1:0] o_drop_count;

   int n_asserts;
   int n_fail;

   logic [31:0] vals [8];
   logic [31:0] v15;

   power_result_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .DROP_W (DROP_W)
   ) dut (
      .clock        (clock),
      .reset        (reset),
      .i_value      (i_value),
      .i_valid      (i_valid),
      .i_clear      (i_clear),
      .o_value      (o_value),
      .o_valid      (o_valid),
      .o_ready      (o_ready),
      .o_count      (o_count),
      .o_full       (o_full),
      .o_overflow   (o_overflow),
      .o_drop_count (o_drop_count)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_asserts++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic fill_full();
      o_ready = 1'b0;
      for (int i = 0; i < 8; i++) begin
         i_valid = 1'b1;
         i_value = vals[i];
         tick();
      end
      i_valid = 1'b0;
   endtask

   initial begin
      n_asserts = 0;
      n_fail    = 0;
      vals = '{32'd1, 32'd256, 32'd6561, 32'd65536, 32'd390625,
               32'd1679616, 32'd5764801, 32'd16777216};
      v15 = 32'h98C2_9B81;

      reset   = 1'b0;
      i_value = '0;
      i_valid = 1'b0;
      i_clear = 1'b0;
      o_ready = 1'b0;
      tick();
      tick();
      check("rst_valid", 64'(o_valid), 64'd0);
      check("rst_count", 64'(o_count), 64'd0);
      check("rst_value", 64'(o_value), 64'd0);
      check("rst_full", 64'(o_full), 64'd0);
      check("rst_ovf", 64'(o_overflow), 64'd0);
      check("rst_drops", 64'(o_drop_count), 64'd0);
      reset = 1'b1;
      tick();

      // single push with consumer ready
      o_ready = 1'b1;
      i_valid = 1'b1;
      i_value = 32'd256;
      tick();
      i_valid = 1'b0;
      check("one_valid", 64'(o_valid), 64'd1);
      check("one_value", 64'(o_value), 64'd256);
      check("one_count", 64'(o_count), 64'd1);
      tick();
      check("one_drained_valid", 64'(o_valid), 64'd0);
      check("one_drained_count", 64'(o_count), 64'd0);

      // fill to full, no drop, then drain in order
      fill_full();
      check("fill_full", 64'(o_full), 64'd1);
      check("fill_count", 64'(o_count), 64'd8);
      check("fill_ovf", 64'(o_overflow), 64'd0);
      check("fill_drops", 64'(o_drop_count), 64'd0);
      tick();
      check("hold_value", 64'(o_value), 64'(vals[0]));
      check("hold_valid", 64'(o_valid), 64'd1);
      o_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         check($sformatf("drain_%0d", i), 64'(o_value), 64'(vals[i]));
         tick();
      end
      check("drain_empty", 64'(o_valid), 64'd0);
      check("drain_count", 64'(o_count), 64'd0);

      // 9th value dropped while full and stalled
      fill_full();
      i_valid = 1'b1;
      i_value = v15;
      tick();
      i_valid = 1'b0;
      check("drop_ovf", 64'(o_overflow), 64'd1);
      check("drop_cnt", 64'(o_drop_count), 64'd1);
      check("drop_count", 64'(o_count), 64'd8);
      o_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         check($sformatf("drop_drain_%0d", i), 64'(o_value), 64'(vals[i]));
         tick();
      end
      check("drop_never_out", 64'(o_valid), 64'd0);
      i_clear = 1'b1;
      tick();
      i_clear = 1'b0;
      check("clr1_ovf", 64'(o_overflow), 64'd0);
      check("clr1_drops", 64'(o_drop_count), 64'd0);

      // full with simultaneous push and pop
      fill_full();
      i_valid = 1'b1;
      i_value = v15;
      o_ready = 1'b1;
      tick();
      i_valid = 1'b0;
      check("pp_count", 64'(o_count), 64'd8);
      check("pp_ovf", 64'(o_overflow), 64'd0);
      check("pp_drops", 64'(o_drop_count), 64'd0);
      for (int i = 1; i < 8; i++) begin
         check($sformatf("pp_drain_%0d", i), 64'(o_value), 64'(vals[i]));
         tick();
      end
      check("pp_last", 64'(o_value), 64'(v15));
      tick();
      check("pp_empty", 64'(o_valid), 64'd0);

      // saturating drop counter and clear priority
      fill_full();
      i_valid = 1'b1;
      i_value = v15;
      for (int i = 0; i < 300; i++) tick();
      i_valid = 1'b0;
      check("sat_drops", 64'(o_drop_count), 64'd255);
      check("sat_ovf", 64'(o_overflow), 64'd1);
      check("sat_count", 64'(o_count), 64'd8);
      i_clear = 1'b1;
      tick();
      check("clr2_ovf", 64'(o_overflow), 64'd0);
      check("clr2_drops", 64'(o_drop_count), 64'd0);
      i_valid = 1'b1;
      tick();
      i_valid = 1'b0;
      i_clear = 1'b0;
      check("clrdrop_ovf", 64'(o_overflow), 64'd1);
      check("clrdrop_drops", 64'(o_drop_count), 64'd1);
      check("clr_keeps_data", 64'(o_value), 64'(vals[0]));

      // drain three, then asynchronous reset between edges
      o_ready = 1'b1;
      tick();
      tick();
      tick();
      o_ready = 1'b0;
      check("pre_rst_count", 64'(o_count), 64'd5);
      check("pre_rst_value", 64'(o_value), 64'(vals[3]));
      #2;
      reset = 1'b0;
      #1;
      check("arst_valid", 64'(o_valid), 64'd0);
      check("arst_count", 64'(o_count), 64'd0);
      check("arst_value", 64'(o_value), 64'd0);
      check("arst_ovf", 64'(o_overflow), 64'd0);
      check("arst_drops", 64'(o_drop_count), 64'd0);
      tick();
      #3;
      reset = 1'b1;
      tick();
      i_valid = 1'b1;
      i_value = 32'h0000_CAFE;
      tick();
      i_valid = 1'b0;
      check("post_rst_valid", 64'(o_valid), 64'd1);
      check("post_rst_value", 64'(o_value), 64'h0000_CAFE);
      check("post_rst_count", 64'(o_count), 64'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
   end

endmodule
